// File: rtl/universal_shift_register.sv
// Universal shift register with a small IDLE/SHIFT/DONE sequencer.
//
// A start request in IDLE captures mode and amt. Shift-type modes then run for
// amt clock edges, one position per edge, before a one-cycle done pulse.
// Parallel load, hold, reserved modes and amt=0 complete directly via DONE.
//
// Parameters:
//   N      register width in bits (N >= 2)
//   CW     shift-count width, $clog2(N)+1
// Ports:
//   clk    clock, rising-edge active
//   rst    asynchronous active-low reset
//   start  operation request, sampled only in IDLE
//   mode   operation code: 000 hold, 001 shr, 010 shl, 011 ror, 100 rol,
//          101 asr, 110 load, 111 hold
//   amt    shift count, captured with start
//   d      parallel load data
//   si_l   serial input entering the MSB on shift right
//   si_r   serial input entering the LSB on shift left
//   abort  (only with USR_ABORT_EN) cancel an in-progress shift
//   q      register contents
//   so_l   q[N-1], combinational
//   so_r   q[0], combinational
//   busy   high while shifting
//   done   one-cycle completion pulse
//
// Optional feature: define USR_ABORT_EN to add the abort input.
module universal_shift_register #(
  parameter int N = 8,
  localparam int CW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [CW-1:0] amt,
  input  logic [N-1:0]  d,
  input  logic          si_l,
  input  logic          si_r,
`ifdef USR_ABORT_EN
  input  logic          abort,
`endif
  output logic [N-1:0]  q,
  output logic          so_l,
  output logic          so_r,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e        state;
  logic [2:0]    op;
  logic [CW-1:0] cnt;
  logic [N-1:0]  shift_val;
  logic          abort_hit;
  logic          is_shift_mode;

`ifdef USR_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign so_l = q[N-1];
  assign so_r = q[0];

  assign is_shift_mode = (mode >= 3'd1) && (mode <= 3'd5);

  // One position of the captured operation; serial inputs are taken live.
  always_comb begin
    shift_val = q;
    case (op)
      3'd1:    shift_val = {si_l, q[N-1:1]};
      3'd2:    shift_val = {q[N-2:0], si_r};
      3'd3:    shift_val = {q[0], q[N-1:1]};
      3'd4:    shift_val = {q[N-2:0], q[N-1]};
      3'd5:    shift_val = {q[N-1], q[N-1:1]};
      default: shift_val = q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= StIdle;
      op    <= 3'd0;
      cnt   <= '0;
      q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            if (is_shift_mode && (amt != '0)) begin
              op    <= mode;
              cnt   <= amt;
              state <= StShift;
              busy  <= 1'b1;
            end else begin
              if (mode == 3'd6) begin
                q <= d;
              end
              state <= StDone;
              done  <= 1'b1;
            end
          end
        end
        StShift: begin
          if (abort_hit) begin
            // Keep the partial result, no completion pulse.
            cnt   <= '0;
            state <= StIdle;
            busy  <= 1'b0;
          end else begin
            q   <= shift_val;
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              state <= StDone;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        StDone: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (N=8): directed scenarios
// followed by randomized operations checked against an arithmetic model.
module tb_universal_shift_register;

  localparam int N = 8;
  localparam int CW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    mode;
  logic [CW-1:0] amt;
  logic [N-1:0]  d;
  logic          si_l;
  logic          si_r;
`ifdef USR_ABORT_EN
  logic          abort;
`endif
  logic [N-1:0]  q;
  logic          so_l;
  logic          so_r;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q;

  always #5 clk = ~clk;

  universal_shift_register #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .amt   (amt),
    .d     (d),
    .si_l  (si_l),
    .si_r  (si_r),
`ifdef USR_ABORT_EN
    .abort (abort),
`endif
    .q     (q),
    .so_l  (so_l),
    .so_r  (so_r),
    .busy  (busy),
    .done  (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: one shift position computed with plain integer arithmetic.
  function automatic logic [7:0] step(input logic [7:0] v, input logic [2:0] m,
                                      input bit sl, input bit sr);
    int x;
    int r;
    x = int'(v);
    case (m)
      3'd1:    r = (x / 2) + (sl ? 128 : 0);
      3'd2:    r = ((x * 2) % 256) + (sr ? 1 : 0);
      3'd3:    r = (x / 2) + ((x % 2) * 128);
      3'd4:    r = ((x * 2) % 256) + (x / 128);
      3'd5:    r = (x / 2) + ((x >= 128) ? 128 : 0);
      default: r = x;
    endcase
    return 8'(r);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_q"}, 32'(q), 32'(exp_q));
    check({tag, "_so_l"}, 32'(so_l), 32'(exp_q[7]));
    check({tag, "_so_r"}, 32'(so_r), 32'(exp_q[0]));
  endtask

  // Called right after a falling edge; returns right after a falling edge.
  task automatic do_op(input logic [2:0] m, input logic [3:0] a, input logic [7:0] dv,
                       input bit rnd, input bit sl, input bit sr, input bit poke);
    bit is_shift;
    bit sl_now;
    bit sr_now;
    is_shift = (m >= 3'd1) && (m <= 3'd5) && (a != 4'd0);
    start = 1'b1;
    mode  = m;
    amt   = a;
    d     = dv;
    si_l  = rnd ? 1'($urandom) : sl;
    si_r  = rnd ? 1'($urandom) : sr;
    @(negedge clk);
    start = 1'b0;
    mode  = 3'($urandom);
    amt   = 4'($urandom);
    d     = 8'($urandom);
    if (!is_shift) begin
      if (m == 3'd6) exp_q = dv;
      check_idle_outputs("imm");
      check("imm_busy", 32'(busy), 32'd0);
      check("imm_done", 32'(done), 32'd1);
      @(negedge clk);
      check("imm_done_end", 32'(done), 32'd0);
      check("imm_busy_end", 32'(busy), 32'd0);
      check("imm_q_end", 32'(q), 32'(exp_q));
    end else begin
      for (int i = 0; i < int'(a); i++) begin
        check("sh_q", 32'(q), 32'(exp_q));
        check("sh_busy", 32'(busy), 32'd1);
        check("sh_done", 32'(done), 32'd0);
        sl_now = rnd ? 1'($urandom) : sl;
        sr_now = rnd ? 1'($urandom) : sr;
        si_l = sl_now;
        si_r = sr_now;
        if (poke && i == 1) begin
          start = 1'b1;
          mode  = 3'd6;
          d     = ~exp_q;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        exp_q = step(exp_q, m, sl_now, sr_now);
      end
      start = 1'b0;
      check_idle_outputs("fin");
      check("fin_busy", 32'(busy), 32'd0);
      check("fin_done", 32'(done), 32'd1);
      @(negedge clk);
      check("fin_done_end", 32'(done), 32'd0);
      check("fin_q_end", 32'(q), 32'(exp_q));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    mode  = 3'd0;
    amt   = '0;
    d     = 8'd0;
    si_l  = 1'b0;
    si_r  = 1'b0;
`ifdef USR_ABORT_EN
    abort = 1'b0;
`endif
    exp_q = 8'h00;
    #3;
    check("rst_q", 32'(q), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Parallel load, then rotate right by 3.
    do_op(3'd6, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("load_a5", 32'(q), 32'hA5);
    do_op(3'd3, 4'd3, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ror3", 32'(q), 32'hB4);

    // Arithmetic shift right keeps the sign bit.
    do_op(3'd6, 4'd0, 8'h84, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(3'd5, 4'd2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("asr2", 32'(q), 32'hE1);
    check("asr2_so_r", 32'(so_r), 32'd1);

    // Shift left with ones, with a start pulse mid-shift that must be ignored.
    do_op(3'd6, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(3'd2, 4'd4, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    check("shl4", 32'(q), 32'h0F);

    // Hold, reserved and amt=0 leave q alone.
    do_op(3'd0, 4'd5, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(3'd7, 4'd2, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(3'd1, 4'd0, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0);
    check("hold_q", 32'(q), 32'h0F);

    // Asynchronous reset in the middle of a shift.
    do_op(3'd6, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    mode  = 3'd1;
    amt   = 4'd5;
    si_l  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_q", 32'(q), 32'h29);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_q", 32'(q), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    check("in_rst_done", 32'(done), 32'd0);
    rst = 1'b1;
    exp_q = 8'h00;
    // First start is taken on the first rising edge after release.
    do_op(3'd6, 4'd0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_rst_load", 32'(q), 32'h3C);

`ifdef USR_ABORT_EN
    do_op(3'd6, 4'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    mode  = 3'd2;
    amt   = 4'd6;
    si_r  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_pre_q", 32'(q), 32'hFC);
    check("abort_pre_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_q", 32'(q), 32'hFC);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    check("abort_done_after", 32'(done), 32'd0);
    exp_q = 8'hFC;
    do_op(3'd4, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_then_rol", 32'(q), 32'hF9);
`endif

    // Randomized operations against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      logic [2:0] rm;
      logic [3:0] ra;
      rm = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 12));
      do_op(rm, ra, 8'($urandom), 1'b1, 1'b0, 1'b0, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 SHALL have parameter N, default 8, meaning register width in bits (N >= 2).
REQ-002 SHALL have localparam CW = $clog2(N)+1, meaning shift-amount width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  operation request, sampled only in IDLE.
REQ-006 SHALL have port mode  input  3  operation code, captured with start.
REQ-007 SHALL have port amt  input  CW  shift count, captured with start.
REQ-008 SHALL have port d  input  N  parallel load data.
REQ-009 SHALL have port si_l  input  1  serial input entering MSB on shift right.
REQ-010 SHALL have port si_r  input  1  serial input entering LSB on shift left.
REQ-011 SHALL have port q  output  N  register contents (registered).
REQ-012 SHALL have ports so_l / so_r  output  1 each  combinational q[N-1] / q[0].
REQ-013 SHALL have port busy  output  1  high while in SHIFT state.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL decode mode: 000 hold, 001 shift right {si_l,q[N-1:1]}, 010 shift left {q[N-2:0],si_r}, 011 rotate right, 100 rotate left, 101 arithmetic shift right (MSB replicated), 110 parallel load, 111 reserved = hold.
REQ-016 SHALL implement FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-017 SHALL, in IDLE with start=1 and mode in {001..101} and amt>0, capture mode/amt, load remaining-count = amt, enter SHIFT; q unchanged on that edge.
REQ-018 SHALL, in SHIFT, perform exactly one position of the captured operation per clock edge and decrement remaining-count; after the amt-th shift edge enter DONE.
REQ-019 SHALL sample si_l/si_r live on each shift edge (not captured at start).
REQ-020 SHALL, in IDLE with start=1 and mode=110, load q<=d on that edge and enter DONE.
REQ-021 SHALL, in IDLE with start=1 and mode in {000,111} or amt=0, leave q unchanged and enter DONE.
REQ-022 SHALL assert done only in DONE, for exactly one cycle, then return to IDLE unconditionally.
REQ-023 SHALL ignore start in SHIFT and DONE (no queuing); mode/amt/d changes outside the IDLE capture edge have no effect.
REQ-024 SHALL keep busy=0 in IDLE and DONE; busy and done never both high.
REQ-025 SHALL give latency: load/hold/amt=0 -> done one cycle after start edge; shift by k -> k shift edges after start edge, done in following cycle.

Reset
REQ-026 SHALL, on rst=0, asynchronously force q=0, state=IDLE, remaining-count=0, busy=0, done=0, independent of clk.
REQ-027 SHALL abandon any in-progress operation on reset without a done pulse; first start accepted on first rising edge after rst deasserts.

Configuration
REQ-028 SHALL, with USR_ABORT_EN defined, add input port abort (1 bit): abort=1 in SHIFT returns to IDLE on next edge without shifting, q retains partial result, no done pulse; abort ignored in IDLE/DONE.
REQ-029 SHALL, without USR_ABORT_EN, have no abort port and SHIFT always runs to completion.

Verification (N=8)
REQ-030 SHALL cover: reset, start mode=110 d=0xA5 -> q=0xA5 after start edge, done=1 next cycle, busy never high.
REQ-031 SHALL cover: q=0xA5, mode=011 amt=3 -> q sequence 0xD2, 0x69, 0xB4, busy=1 for 3 cycles, then done=1 once.
REQ-032 SHALL cover: q=0x84, mode=101 amt=2 -> q=0xC2 then 0xE1; so_r=1 at end.
REQ-033 SHALL cover: q=0x00, mode=010 amt=4 si_r=1 -> q=0x0F; start pulsed mid-SHIFT with mode=110 has no effect.
REQ-034 SHALL cover: q=0xA5, mode=001 amt=5 si_l=0, rst=0 after 2 shifts (between edges) -> q=0x00, busy=0, done=0 immediately; no done pulse afterward.
REQ-035 SHALL cover (USR_ABORT_EN): q=0xFF, mode=010 amt=6 si_r=0, abort after 2 shifts -> q=0xFC, IDLE next cycle, done stays 0.
